// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion (1-cycle D->E, StallD back to IF/ID).
// Optional macro ID_EX_PERF_EN builds the BubbleCnt performance counter; otherwise BubbleCnt is 0.
module id_ex_stage_reg #(
  parameter int LOAD_USE_BUBBLES = 1  // legal range 1..3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        FlushE,
  input  logic        RegWriteD,
  input  logic        MemWriteD,
  input  logic        LoadD,
  input  logic        BranchD,
  input  logic        JumpD,
  input  logic        ALUSrcD,
  input  logic [3:0]  ALUControlD,
  input  logic [31:0] RD1_D,
  input  logic [31:0] RD2_D,
  input  logic [31:0] ImmExtD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic [4:0]  RS1_D,
  input  logic [4:0]  RS2_D,
  input  logic [4:0]  RD_D,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        LoadE,
  output logic        BranchE,
  output logic        JumpE,
  output logic        ALUSrcE,
  output logic [3:0]  ALUControlE,
  output logic [31:0] RD1_E,
  output logic [31:0] RD2_E,
  output logic [31:0] ImmExtE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E,
  output logic [4:0]  RS1_E,
  output logic [4:0]  RS2_E,
  output logic [4:0]  RD_E,
  output logic        StoreE,
  output logic        ValidE,
  output logic        StallD,
  output logic [31:0] BubbleCnt
);

  typedef enum logic {IDLE, HOLD} state_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        load;
    logic        branch;
    logic        jump;
    logic        alu_src;
    logic [3:0]  alu_ctl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        valid;
  } ex_t;

  state_t     state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  ex_t        ex_q, d_bus;
  logic       haz, bubble;

  assign d_bus = '{reg_write: RegWriteD, mem_write: MemWriteD, load: LoadD,
                   branch: BranchD, jump: JumpD, alu_src: ALUSrcD,
                   alu_ctl: ALUControlD, rd1: RD1_D, rd2: RD2_D, imm: ImmExtD,
                   pc: PCD, pc_plus4: PCPlus4D, rs1: RS1_D, rs2: RS2_D,
                   rd: RD_D, valid: 1'b1};

  // Conservative: any rs index match counts, whether or not the operand is used.
  assign haz = ex_q.valid & ex_q.load & (ex_q.rd != 5'd0) &
               ((ex_q.rd == RS1_D) | (ex_q.rd == RS2_D));

  assign StallD = !FlushE & (haz | (state == HOLD));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bubble    = 1'b0;
    if (FlushE) begin
      bubble    = 1'b1;
      state_nxt = IDLE;
      cnt_nxt   = 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (haz) begin
            bubble = 1'b1;
            if (LOAD_USE_BUBBLES > 1) begin
              state_nxt = HOLD;
              cnt_nxt   = 2'(LOAD_USE_BUBBLES - 1);
            end
          end
        end
        HOLD: begin
          bubble  = 1'b1;
          cnt_nxt = cnt - 2'd1;
          if (cnt == 2'd1) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ex_q <= '0;
    else if (bubble) ex_q <= '0;
    else             ex_q <= d_bus;
  end

`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         bubble_cnt <= 32'd0;
    else if (bubble) bubble_cnt <= bubble_cnt + 32'd1;
  end

  assign BubbleCnt = bubble_cnt;
`else
  assign BubbleCnt = 32'h0;
`endif

  assign RegWriteE   = ex_q.reg_write;
  assign MemWriteE   = ex_q.mem_write;
  assign StoreE      = ex_q.mem_write;
  assign LoadE       = ex_q.load;
  assign BranchE     = ex_q.branch;
  assign JumpE       = ex_q.jump;
  assign ALUSrcE     = ex_q.alu_src;
  assign ALUControlE = ex_q.alu_ctl;
  assign RD1_E       = ex_q.rd1;
  assign RD2_E       = ex_q.rd2;
  assign ImmExtE     = ex_q.imm;
  assign PCE         = ex_q.pc;
  assign PCPlus4E    = ex_q.pc_plus4;
  assign RS1_E       = ex_q.rs1;
  assign RS2_E       = ex_q.rs2;
  assign RD_E        = ex_q.rd;
  assign ValidE      = ex_q.valid;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: two instances (1 and 2 bubbles per load-use) on shared inputs,
// compared against an instruction-level model that tracks bubbles still owed per instance.
module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        FlushE, RegWriteD, MemWriteD, LoadD, BranchD, JumpD, ALUSrcD;
  logic [3:0]  ALUControlD;
  logic [31:0] RD1_D, RD2_D, ImmExtD, PCD, PCPlus4D;
  logic [4:0]  RS1_D, RS2_D, RD_D;

  always #5 clk = ~clk;

  typedef struct packed {
    logic        reg_write, mem_write, load, branch, jump, alu_src;
    logic [3:0]  alu_ctl;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
    logic        store, valid, stall;
    logic [31:0] bcnt;
  } obs_t;

  localparam int LUB [2] = '{1, 2};

  obs_t obs [2];
  obs_t mdl [2];
  int   owed [2];
  int   bubbles [2];
  int   n_chk = 0;
  int   n_fail = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic        rw, mw, ld, br, jp, as, st, vl, sd;
    logic [3:0]  alu;
    logic [31:0] r1, r2, im, pc, p4, bc;
    logic [4:0]  s1, s2, d;

    id_ex_stage_reg #(.LOAD_USE_BUBBLES(LUB[g])) dut (
      .clk(clk), .rst(rst), .FlushE(FlushE),
      .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .LoadD(LoadD),
      .BranchD(BranchD), .JumpD(JumpD), .ALUSrcD(ALUSrcD),
      .ALUControlD(ALUControlD), .RD1_D(RD1_D), .RD2_D(RD2_D),
      .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
      .RS1_D(RS1_D), .RS2_D(RS2_D), .RD_D(RD_D),
      .RegWriteE(rw), .MemWriteE(mw), .LoadE(ld), .BranchE(br), .JumpE(jp),
      .ALUSrcE(as), .ALUControlE(alu), .RD1_E(r1), .RD2_E(r2),
      .ImmExtE(im), .PCE(pc), .PCPlus4E(p4), .RS1_E(s1), .RS2_E(s2),
      .RD_E(d), .StoreE(st), .ValidE(vl), .StallD(sd), .BubbleCnt(bc)
    );

    assign obs[g] = '{reg_write: rw, mem_write: mw, load: ld, branch: br,
                      jump: jp, alu_src: as, alu_ctl: alu, rd1: r1, rd2: r2,
                      imm: im, pc: pc, pc4: p4, rs1: s1, rs2: s2, rd: d,
                      store: st, valid: vl, stall: sd, bcnt: bc};
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: the older instruction in E is a load whose rd is read by the one in D.
  function automatic logic load_use(int k);
    return mdl[k].valid && mdl[k].load && mdl[k].rd != 0 &&
           (mdl[k].rd == RS1_D || mdl[k].rd == RS2_D);
  endfunction

  function automatic logic exp_stall(int k);
    return !FlushE && (load_use(k) || owed[k] > 0);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mdl[k] = '0; owed[k] = 0; bubbles[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic lu;
      lu = load_use(k);
      if (FlushE || owed[k] > 0 || lu) begin
        if (FlushE)      owed[k] = 0;
        else if (owed[k] > 0) owed[k] = owed[k] - 1;
        else             owed[k] = LUB[k] - 1;
        mdl[k] = '0;
        bubbles[k]++;
      end else begin
        mdl[k] = '{reg_write: RegWriteD, mem_write: MemWriteD, load: LoadD,
                   branch: BranchD, jump: JumpD, alu_src: ALUSrcD,
                   alu_ctl: ALUControlD, rd1: RD1_D, rd2: RD2_D, imm: ImmExtD,
                   pc: PCD, pc4: PCPlus4D, rs1: RS1_D, rs2: RS2_D, rd: RD_D,
                   store: MemWriteD, valid: 1'b1, stall: 1'b0, bcnt: 32'd0};
      end
    end
  endtask

  task automatic cmp_all(string ph);
    for (int k = 0; k < 2; k++) begin
      obs_t o, e;
      o = obs[k];
      e = mdl[k];
      chk($sformatf("%s[%0d].valid", ph, k), 32'(o.valid), 32'(e.valid));
      chk($sformatf("%s[%0d].ctl", ph, k),
          32'({o.reg_write, o.mem_write, o.load, o.branch, o.jump, o.alu_src, o.alu_ctl, o.store}),
          32'({e.reg_write, e.mem_write, e.load, e.branch, e.jump, e.alu_src, e.alu_ctl, e.mem_write}));
      chk($sformatf("%s[%0d].rd1", ph, k), o.rd1, e.rd1);
      chk($sformatf("%s[%0d].rd2", ph, k), o.rd2, e.rd2);
      chk($sformatf("%s[%0d].imm", ph, k), o.imm, e.imm);
      chk($sformatf("%s[%0d].pc", ph, k), o.pc, e.pc);
      chk($sformatf("%s[%0d].pc4", ph, k), o.pc4, e.pc4);
      chk($sformatf("%s[%0d].idx", ph, k), 32'({o.rs1, o.rs2, o.rd}), 32'({e.rs1, e.rs2, e.rd}));
      chk($sformatf("%s[%0d].stall", ph, k), 32'(o.stall), 32'(rst ? 1'b0 : exp_stall(k)));
`ifdef ID_EX_PERF_EN
      chk($sformatf("%s[%0d].bcnt", ph, k), o.bcnt, 32'(bubbles[k]));
`else
      chk($sformatf("%s[%0d].bcnt", ph, k), o.bcnt, 32'd0);
`endif
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle(string ph);
    #1;
    cmp_all(ph);
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_instr(logic rw, logic mw, logic ld, logic [4:0] s1,
                           logic [4:0] s2, logic [4:0] d, logic [31:0] r1,
                           logic [31:0] r2);
    RegWriteD = rw; MemWriteD = mw; LoadD = ld; BranchD = 0; JumpD = 0;
    ALUSrcD = ld; ALUControlD = 4'h0; RS1_D = s1; RS2_D = s2; RD_D = d;
    RD1_D = r1; RD2_D = r2; ImmExtD = 32'h10; PCD = PCD + 32'd4;
    PCPlus4D = PCD + 32'd4;
  endtask

  task automatic rand_d();
    RegWriteD = 1'($urandom); MemWriteD = 1'($urandom);
    LoadD = ($urandom_range(0, 2) == 0); BranchD = 1'($urandom);
    JumpD = 1'($urandom); ALUSrcD = 1'($urandom); ALUControlD = 4'($urandom);
    RD1_D = $urandom; RD2_D = $urandom; ImmExtD = $urandom;
    PCD = $urandom; PCPlus4D = $urandom;
    RS1_D = 5'($urandom_range(0, 3)); RS2_D = 5'($urandom_range(0, 3));
    RD_D = 5'($urandom_range(0, 3));
  endtask

  initial begin
    int nst;
    rst = 1'b1; FlushE = 0; PCD = 32'h0;
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk); @(negedge clk);
    #1 cmp_all("reset");
    rst = 1'b0;

    // add x3,x1,x2
    set_instr(1, 0, 0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
    cycle("add");
    chk("t2.rd1", obs[0].rd1, 32'd5);
    chk("t2.rd2", obs[0].rd2, 32'd7);
    chk("t2.rd", 32'(obs[0].rd), 32'd3);
    chk("t2.regwrite", 32'(obs[0].reg_write), 32'd1);
    chk("t2.valid", 32'(obs[0].valid), 32'd1);

    // lw x5 then add x6,x5,x1
    set_instr(1, 0, 1, 5'd1, 5'd0, 5'd5, 32'd9, 32'd0);
    cycle("lw5");
    set_instr(1, 0, 0, 5'd5, 5'd1, 5'd6, 32'd11, 32'd12);
    #1 chk("t3.stall", 32'(obs[0].stall), 32'd1);
    cycle("use5");
    chk("t3.bub_valid", 32'(obs[0].valid), 32'd0);
    chk("t3.bub_regwrite", 32'(obs[0].reg_write), 32'd0);
    cycle("use5b");
    chk("t3.rs1", 32'(obs[0].rs1), 32'd5);
    chk("t3.valid", 32'(obs[0].valid), 32'd1);
    cycle("use5c");

    // lw x0 followed by a reader of x0
    set_instr(1, 0, 1, 5'd1, 5'd0, 5'd0, 32'd1, 32'd0);
    cycle("lw0");
    set_instr(1, 0, 0, 5'd0, 5'd0, 5'd7, 32'd21, 32'd22);
    #1 chk("t4.stall", 32'(obs[0].stall), 32'd0);
    cycle("use0");
    chk("t4.rd", 32'(obs[0].rd), 32'd7);
    chk("t4.valid", 32'(obs[0].valid), 32'd1);

    // hazard with a concurrent flush
    set_instr(1, 0, 1, 5'd2, 5'd0, 5'd8, 32'd3, 32'd0);
    cycle("lw8");
    set_instr(1, 0, 0, 5'd8, 5'd8, 5'd9, 32'd31, 32'd32);
    FlushE = 1;
    #1 chk("t5.stall0", 32'(obs[0].stall), 32'd0);
    chk("t5.stall1", 32'(obs[1].stall), 32'd0);
    cycle("flush");
    chk("t5.valid", 32'(obs[0].valid), 32'd0);
    FlushE = 0;
    #1 chk("t5.idle", 32'(obs[1].stall), 32'd0);
    cycle("postflush");

    for (int i = 0; i < 1500; i++) begin
      if (!(load_use(0) || load_use(1) || owed[0] > 0 || owed[1] > 0)) rand_d();
      FlushE = ($urandom_range(0, 9) == 0);
      cycle("rand");
    end

    // reset asserted while the two-bubble instance is in HOLD
    FlushE = 1;
    cycle("clr");
    FlushE = 0;
    set_instr(1, 0, 1, 5'd1, 5'd0, 5'd5, 32'd9, 32'd0);
    cycle("lwh");
    set_instr(1, 0, 0, 5'd5, 5'd0, 5'd6, 32'd1, 32'd2);
    cycle("hold");
    #1 chk("t1.in_hold", 32'(obs[1].stall), 32'd1);
    rst = 1'b1;
    model_reset();
    #1 cmp_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    #1 chk("t1.stall_after", 32'(obs[1].stall), 32'd0);
    cycle("rst_rel");

    // one load-use on the two-bubble instance
    set_instr(1, 0, 1, 5'd1, 5'd0, 5'd9, 32'd4, 32'd0);
    cycle("lw9");
    set_instr(1, 0, 0, 5'd2, 5'd9, 5'd10, 32'd1, 32'd2);
    nst = 0;
    for (int i = 0; i < 4; i++) begin
      #1 if (obs[1].stall) nst++;
      cycle("lub2");
    end
    chk("t6.stalls", 32'(nst), 32'd2);
`ifdef ID_EX_PERF_EN
    chk("t6.bcnt", obs[1].bcnt, 32'd2);
`else
    chk("t6.bcnt", obs[1].bcnt, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
